// File: rtl/neopixel_receiver.sv
// WS2812 line decoder: measures high/low pulse widths on the synchronized line and
// writes each decoded byte, indexed within the frame, through a one-cycle strobe.
`timescale 1ns/1ps
module neopixel_receiver #(
    parameter int LEDS         = 30,
    parameter int CLK_HZ       = 50_000_000,
    parameter int T_THRESH_NS  = 600,
    parameter int T_MAXHIGH_NS = 2000,
    parameter int T_LATCH_NS   = 50000
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_neopixel_in,
    output logic                         o_wr_en,
    output logic [$clog2(LEDS*3)-1:0]    o_wr_addr,
    output logic [7:0]                   o_wr_data,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic                         o_error
);

    function automatic int ns_to_cycles(input int ns);
        return int'((longint'(CLK_HZ) * longint'(ns)) / longint'(1_000_000_000));
    endfunction

    localparam int NBYTES  = LEDS * 3;
    localparam int ADDR_W  = $clog2(NBYTES);
    localparam int IDX_W   = $clog2(NBYTES + 1);
    localparam int THRESH  = ns_to_cycles(T_THRESH_NS);
    localparam int MAXHIGH = ns_to_cycles(T_MAXHIGH_NS);
    localparam int LATCH   = ns_to_cycles(T_LATCH_NS);
    localparam int CNT_W   = $clog2(LATCH + 1);

    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] MAXHIGH_C = CNT_W'(MAXHIGH);
    localparam logic [CNT_W-1:0] LATCH_C   = CNT_W'(LATCH);
    localparam logic [IDX_W-1:0] NBYTES_C  = IDX_W'(NBYTES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= LATCH_C) ? LATCH_C : c + CNT_W'(1);
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

    state_t             state;
    logic               sync_p0;
    logic               sync_p1;
    logic               line_p2;
    logic [1:0]         warm;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic [IDX_W-1:0]   byte_idx;
    logic               pulse_bad;
    logic               start_pend;

    logic               edges_ok;
    logic               rise;
    logic               fall;
    logic               bit_val;

    // Edges are only trusted once both synchronizer stages and the previous-sample
    // flop hold real line samples, so a line already high at reset release is ignored.
    assign edges_ok = (warm == 2'd3);
    assign rise     = edges_ok &&  sync_p1 && !line_p2;
    assign fall     = edges_ok && !sync_p1 &&  line_p2;
    assign bit_val  = (cnt >= THRESH_C);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            sync_p0      <= 1'b0;
            sync_p1      <= 1'b0;
            line_p2      <= 1'b0;
            warm         <= 2'd0;
            cnt          <= '0;
            bit_cnt      <= 3'd0;
            shreg        <= 8'd0;
            byte_idx     <= '0;
            pulse_bad    <= 1'b0;
            start_pend   <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= 8'd0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            // p0/p1: metastability synchronizer; p2: previous sample for edge detect
            sync_p0 <= i_neopixel_in;
            sync_p1 <= sync_p0;
            line_p2 <= sync_p1;
            if (warm != 2'd3) warm <= warm + 2'd1;

            o_wr_en      <= 1'b0;
            o_frame_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rise || start_pend) begin
                        state      <= ST_HIGH;
                        // A deferred start lost one cycle of high time while the old frame closed.
                        cnt        <= start_pend ? CNT_W'(2) : CNT_W'(1);
                        start_pend <= 1'b0;
                        o_busy     <= 1'b1;
                        o_error    <= 1'b0;
                        byte_idx   <= '0;
                        bit_cnt    <= 3'd0;
                        shreg      <= 8'd0;
                        pulse_bad  <= 1'b0;
                    end
                end

                ST_HIGH: begin
                    if (fall) begin
                        state     <= ST_LOW;
                        cnt       <= CNT_W'(1);
                        pulse_bad <= 1'b0;
                        if (pulse_bad || cnt >= MAXHIGH_C) begin
                            o_error <= 1'b1;
                            bit_cnt <= 3'd0;
                            shreg   <= 8'd0;
                        end else begin
                            shreg   <= {shreg[6:0], bit_val};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (byte_idx < NBYTES_C) begin
                                    o_wr_en   <= 1'b1;
                                    o_wr_addr <= byte_idx[ADDR_W-1:0];
                                    o_wr_data <= {shreg[6:0], bit_val};
                                    byte_idx  <= byte_idx + IDX_W'(1);
                                end else begin
                                    o_error <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        cnt <= sat_inc(cnt);
                        if (cnt >= MAXHIGH_C) begin
                            o_error   <= 1'b1;
                            pulse_bad <= 1'b1;
                            bit_cnt   <= 3'd0;
                            shreg     <= 8'd0;
                        end
                    end
                end

                ST_LOW: begin
                    if (cnt >= LATCH_C) begin
                        state        <= ST_IDLE;
                        cnt          <= '0;
                        o_busy       <= 1'b0;
                        o_frame_done <= 1'b1;
                        start_pend   <= rise;
                        if (bit_cnt != 3'd0) o_error <= 1'b1;
                    end else if (rise) begin
                        state <= ST_HIGH;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/neopixel_receiver.md
NEOPIXEL_RECEIVER -- requirements
Module: neopixel_receiver

Interface
REQ-001 The block SHALL have parameter LEDS, default 30: number of LEDs per frame, giving LEDS*3 bytes.
REQ-002 The block SHALL have parameter CLK_HZ, default 50_000_000: i_clk frequency.
REQ-003 The block SHALL have parameter T_THRESH_NS, default 600: a high pulse at or above this width decodes as 1; below it, as 0.
REQ-004 The block SHALL have parameter T_MAXHIGH_NS, default 2000: a high pulse at or above this width is a protocol error.
REQ-005 The block SHALL have parameter T_LATCH_NS, default 50000: a low time at or above this width ends the frame.
REQ-006 The block SHALL have port i_clk, input, 1 bit: single clock.
REQ-007 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port i_neopixel_in, input, 1 bit: asynchronous serial WS2812 line.
REQ-009 The block SHALL have port o_wr_en, output, 1 bit: one-cycle byte write strobe.
REQ-010 The block SHALL have port o_wr_addr, output, $clog2(LEDS*3) bits: byte index within the frame.
REQ-011 The block SHALL have port o_wr_data, output, 8 bits: decoded byte, MSB first on the line.
REQ-012 The block SHALL have port o_busy, output, 1 bit: high from the first rising edge until frame end.
REQ-013 The block SHALL have port o_frame_done, output, 1 bit: one-cycle pulse at latch.
REQ-014 The block SHALL have port o_error, output, 1 bit: sticky until the next frame start.

Function
REQ-015 Cycle counts SHALL be computed at elaboration as CLK_HZ*T_NS/1e9, truncated; at defaults THRESH=30, MAXHIGH=100, LATCH=2500.
REQ-016 i_neopixel_in SHALL pass through a 2-flop synchronizer; edges are detected on the synchronized signal.
REQ-017 States: IDLE, HIGH, LOW. IDLE->HIGH on rising edge; HIGH->LOW on falling edge; LOW->HIGH on rising edge; LOW->IDLE when low count reaches LATCH.
REQ-018 A single counter SHALL clear on every edge and saturate at LATCH; it measures high time in HIGH and low time in LOW.
REQ-019 On HIGH->LOW, the bit SHALL be (count>=THRESH) and shift into an 8-bit register MSB first; the bit counter wraps 7->0.
REQ-020 On the 8th bit, o_wr_en SHALL pulse for exactly one cycle, the cycle after the falling edge is registered, with o_wr_data = byte and o_wr_addr = current byte index.
REQ-021 The byte index SHALL increment after each write.
REQ-022 Bytes at index >= LEDS*3 SHALL be discarded: no o_wr_en, o_error set, and the index does not wrap.
REQ-023 A high count reaching MAXHIGH SHALL set o_error and discard the partial byte; the state stays HIGH until the falling edge, and that pulse produces no bit.
REQ-024 IDLE->HIGH SHALL clear o_error, the byte index, the bit counter and the shift register; it asserts o_busy.
REQ-025 LOW->IDLE SHALL pulse o_frame_done for one cycle and deassert o_busy the same cycle.
REQ-026 A nonzero bit counter at latch SHALL set o_error; the partial byte is not written.
REQ-027 The latch check SHALL take priority: a rising edge in the same cycle the low count reaches LATCH ends the frame first, and the edge starts a new frame from IDLE on the next cycle.
REQ-028 o_wr_addr and o_wr_data SHALL hold their last values between strobes.

Reset
REQ-029 On i_rst_n low, asynchronously: state=IDLE, synchronizer flops=0, all counters=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_frame_done=0, o_error=0.
REQ-030 Reset mid-frame SHALL abandon the frame with no write and no frame_done.
REQ-031 After reset release, a line already high SHALL NOT count as a rising edge.

Verification
REQ-032 Defaults, send byte 0x55 (0: 20 high/40 low cycles; 1: 40/20) then 2500 low -> one o_wr_en with addr 0, data 0x55; o_frame_done ~2500 cycles after the last falling edge; o_error=0.
REQ-033 Loop back with neopixel_driver (LEDS=30) on the R/G/B test pattern -> 90 writes, addresses 0..89, data equal to source memory, one frame_done, o_error=0.
REQ-034 High pulse of 29 cycles vs 30 cycles -> decodes as 0 vs 1 respectively.
REQ-035 Send 91 bytes -> 90 writes, o_error=1 at the 91st byte, frame_done still pulses; next frame start clears o_error.
REQ-036 120-cycle high pulse mid-byte, or 12 bits then latch -> o_error=1, no write for the partial byte.
REQ-037 Assert i_rst_n low after 5 bytes -> all outputs 0 immediately; the next full frame decodes from addr 0.
